// File: rtl/video_payload_tx.sv
// SPI payload transmitter: preamble, 0xFF header, sourced payload bytes and trailer,
// burst-clocked MSB first. Optional build macro SPI_TX_GAP_EN adds an idle gap after payload bytes.
module video_payload_tx #(
  parameter int unsigned CLK_DIV_HALF   = 20,
  parameter int unsigned PREAMBLE_BYTES = 9,
  parameter int unsigned PAYLOAD_BYTES  = 90,
  parameter int unsigned TRAILER_BYTES  = 2,
  parameter int unsigned GAP_CYCLES     = 40
) (
  input  logic       CLK_40,
  input  logic       reset,
  input  logic       chip_select,
  input  logic [7:0] src_data,
  input  logic       src_valid,
  output logic       src_ready,
  output logic       SPI_clk,
  output logic       MISO,
  output logic       busy,
  output logic       done
);

  localparam int unsigned DivW = $clog2(CLK_DIV_HALF);

  localparam logic [2:0] StIdle        = 3'd0;
  localparam logic [2:0] StPreamble    = 3'd1;
  localparam logic [2:0] StHeader      = 3'd2;
  localparam logic [2:0] StPayloadWait = 3'd3;
  localparam logic [2:0] StPayload     = 3'd4;
  localparam logic [2:0] StTrailer     = 3'd5;
  localparam logic [2:0] StDone        = 3'd6;
`ifdef SPI_TX_GAP_EN
  localparam logic [2:0] StGap         = 3'd7;
`endif

  if (CLK_DIV_HALF < 2 || PREAMBLE_BYTES < 1 || PAYLOAD_BYTES < 1 || PAYLOAD_BYTES > 256 ||
      TRAILER_BYTES < 1 || GAP_CYCLES > 60000) begin : g_bad_param
    $error("video_payload_tx: illegal parameter value");
  end

  logic [2:0]      r_state;
  logic [7:0]      r_cnt;
  logic [DivW-1:0] r_div;
  logic            r_sclk;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            r_miso;
  logic            r_cs;
  logic            r_cs_prev;

  logic [2:0]      w_state_d;
  logic [7:0]      w_cnt_d;
  logic [DivW-1:0] w_div_d;
  logic            w_sclk_d;
  logic [2:0]      w_bit_d;
  logic [7:0]      w_shift_d;
  logic            w_miso_d;
  logic            w_sending;
  logic            w_tick;
  logic            w_byte_end;
  logic            w_load;
  logic [7:0]      w_load_byte;

`ifdef SPI_TX_GAP_EN
  logic [15:0]     r_gap;
  logic [15:0]     w_gap_d;
`endif

  assign SPI_clk = r_sclk;
  assign MISO    = r_miso;
  assign busy    = (r_state != StIdle);
  assign done    = (r_state == StDone);

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_div_d     = r_div;
    w_sclk_d    = r_sclk;
    w_bit_d     = r_bit;
    w_shift_d   = r_shift;
    w_miso_d    = r_miso;
    w_load      = 1'b0;
    w_load_byte = 8'h00;
    src_ready   = 1'b0;
`ifdef SPI_TX_GAP_EN
    w_gap_d     = r_gap;
`endif

    w_sending  = (r_state == StPreamble) || (r_state == StHeader) ||
                 (r_state == StPayload) || (r_state == StTrailer);
    w_tick     = (r_div == DivW'(CLK_DIV_HALF - 1));
    w_byte_end = w_sending && w_tick && r_sclk && (r_bit == 3'd7);

    // Bit cell: low half then high half; next bit is presented as SPI_clk falls.
    if (w_sending) begin
      if (w_tick) begin
        w_div_d = '0;
        if (!r_sclk) begin
          w_sclk_d = 1'b1;
        end else begin
          w_sclk_d = 1'b0;
          if (r_bit != 3'd7) begin
            w_bit_d   = r_bit + 3'd1;
            w_shift_d = {r_shift[6:0], 1'b0};
            w_miso_d  = r_shift[6];
          end
        end
      end else begin
        w_div_d = r_div + DivW'(1);
      end
    end

    case (r_state)
      StIdle: begin
        if (r_cs_prev && !r_cs) begin
          w_state_d = StPreamble;
          w_cnt_d   = 8'd0;
          w_load    = 1'b1;
        end
      end
      StPreamble: begin
        if (w_byte_end) begin
          w_load = 1'b1;
          if (r_cnt == 8'(PREAMBLE_BYTES - 1)) begin
            w_state_d   = StHeader;
            w_cnt_d     = 8'd0;
            w_load_byte = 8'hFF;
          end else begin
            w_cnt_d = r_cnt + 8'd1;
          end
        end
      end
      StHeader: begin
        if (w_byte_end) begin
          w_cnt_d = 8'd0;
          if (src_valid) begin
            src_ready   = 1'b1;
            w_load      = 1'b1;
            w_load_byte = src_data;
            w_state_d   = StPayload;
          end else begin
            w_state_d = StPayloadWait;
          end
        end
      end
      StPayloadWait: begin
        if (src_valid) begin
          src_ready   = 1'b1;
          w_load      = 1'b1;
          w_load_byte = src_data;
          w_state_d   = StPayload;
        end
      end
      StPayload: begin
        if (w_byte_end) begin
          if (r_cnt == 8'(PAYLOAD_BYTES - 1)) begin
            w_state_d = StTrailer;
            w_cnt_d   = 8'd0;
            w_load    = 1'b1;
          end else begin
            w_cnt_d = r_cnt + 8'd1;
`ifdef SPI_TX_GAP_EN
            w_state_d = StGap;
            w_gap_d   = 16'd0;
`else
            // Skip the wait state when data is ready so bytes stay back-to-back.
            if (src_valid) begin
              src_ready   = 1'b1;
              w_load      = 1'b1;
              w_load_byte = src_data;
            end else begin
              w_state_d = StPayloadWait;
            end
`endif
          end
        end
      end
      StTrailer: begin
        if (w_byte_end) begin
          if (r_cnt == 8'(TRAILER_BYTES - 1)) begin
            w_state_d = StDone;
          end else begin
            w_cnt_d = r_cnt + 8'd1;
            w_load  = 1'b1;
          end
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
`ifdef SPI_TX_GAP_EN
      // Gap plus the wait-state latch cycle spans GAP_CYCLES and one idle bit cell.
      StGap: begin
        if (r_gap == 16'(GAP_CYCLES + 2 * CLK_DIV_HALF - 2)) begin
          w_state_d = StPayloadWait;
        end else begin
          w_gap_d = r_gap + 16'd1;
        end
      end
`endif
      default: begin
        w_state_d = StIdle;
      end
    endcase

    if (w_load) begin
      w_shift_d = w_load_byte;
      w_miso_d  = w_load_byte[7];
      w_bit_d   = 3'd0;
      w_div_d   = '0;
      w_sclk_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK_40) begin
    if (reset) begin
      r_state   <= StIdle;
      r_cnt     <= 8'd0;
      r_div     <= '0;
      r_sclk    <= 1'b0;
      r_bit     <= 3'd0;
      r_shift   <= 8'd0;
      r_miso    <= 1'b0;
      r_cs      <= 1'b1;
      r_cs_prev <= 1'b1;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_div     <= w_div_d;
      r_sclk    <= w_sclk_d;
      r_bit     <= w_bit_d;
      r_shift   <= w_shift_d;
      r_miso    <= w_miso_d;
      r_cs      <= chip_select;
      r_cs_prev <= r_cs;
    end
  end

`ifdef SPI_TX_GAP_EN
  always_ff @(posedge CLK_40) begin
    if (reset) begin
      r_gap <= 16'd0;
    end else begin
      r_gap <= w_gap_d;
    end
  end
`endif

endmodule

// File: tb/tb_video_payload_tx.sv
// Scoreboard bench for video_payload_tx: decodes MISO on SPI_clk rising edges and checks
// framing, timing, stalls, reset abort and chip_select glitches.
module tb_video_payload_tx;

  localparam int unsigned H      = 4;
  localparam int unsigned PRE    = 9;
  localparam int unsigned PAY    = 90;
  localparam int unsigned TRL    = 2;
  localparam int unsigned GAP    = 40;
  localparam int unsigned NBYTES = PRE + 1 + PAY + TRL;
  localparam int unsigned LIMIT  = 20000;

  logic       CLK_40      = 1'b0;
  logic       reset       = 1'b1;
  logic       chip_select = 1'b1;
  logic [7:0] src_data    = 8'h00;
  logic       src_valid   = 1'b0;
  logic       src_ready;
  logic       SPI_clk;
  logic       MISO;
  logic       busy;
  logic       done;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] pat[3];
  int         rise_cnt, done_cnt, ready_cnt, busy_cyc, done_cyc, max_quiet;
  int         rise_t[NBYTES*8];
  bit         saw_done;

  always #5 CLK_40 = ~CLK_40;

  video_payload_tx #(
    .CLK_DIV_HALF  (H),
    .PREAMBLE_BYTES(PRE),
    .PAYLOAD_BYTES (PAY),
    .TRAILER_BYTES (TRL),
    .GAP_CYCLES    (GAP)
  ) dut (
    .CLK_40     (CLK_40),
    .reset      (reset),
    .chip_select(chip_select),
    .src_data   (src_data),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .SPI_clk    (SPI_clk),
    .MISO       (MISO),
    .busy       (busy),
    .done       (done)
  );

  // Runs one payload with an optional source stall, mid-run reset or chip_select glitch.
  task automatic run_payload(input int stall_idx, input int stall_len, input int reset_at,
                             input bit toggle);
    int         cyc       = 0;
    int         src_idx   = 0;
    int         stall_ctr = 0;
    int         quiet     = 0;
    int         bit_n     = 0;
    logic       prev_sclk = 1'b0;
    logic       prev_miso = 1'b0;
    logic       prev_busy = 1'b0;
    bit         taken     = 1'b0;
    logic [7:0] sh        = 8'h00;
    logic [7:0] want;
    exp_q.delete();
    rise_cnt = 0; done_cnt = 0; ready_cnt = 0; busy_cyc = -1; done_cyc = -1; max_quiet = 0;
    saw_done = 1'b0;
    for (int i = 0; i < PRE; i++) exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    for (int i = 0; i < PAY; i++) exp_q.push_back(pat[i % 3]);
    for (int i = 0; i < TRL; i++) exp_q.push_back(8'h00);
    src_data    = pat[0];
    src_valid   = 1'b1;
    chip_select = 1'b1;
    repeat (3) @(posedge CLK_40);
    #1 chip_select = 1'b0;
    while (!saw_done && cyc < LIMIT) begin
      @(posedge CLK_40);
      #1;
      if (taken) begin
        src_idx++;
        src_data = pat[src_idx % 3];
        taken    = 1'b0;
      end
      if (src_idx == stall_idx && stall_ctr < stall_len) begin
        src_valid = 1'b0;
        stall_ctr++;
      end else begin
        src_valid = 1'b1;
      end
      if (toggle && cyc == 100) chip_select = 1'b1;
      if (toggle && cyc == 110) chip_select = 1'b0;
      if (reset_at > 0 && cyc == reset_at) begin
        reset       = 1'b1;
        chip_select = 1'b1;
        @(posedge CLK_40);
        @(negedge CLK_40);
        n_tests++;
        if ({SPI_clk, MISO, src_ready, busy, done} !== 5'b00000) begin
          n_fail++;
          $display("FAIL reset_abort_outputs: got %b, required 00000",
                   {SPI_clk, MISO, src_ready, busy, done});
        end
        break;
      end
      @(negedge CLK_40);
      cyc++;
      if (src_ready) begin
        taken = 1'b1;
        ready_cnt++;
      end
      if (busy && !prev_busy) busy_cyc = cyc;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        saw_done = 1'b1;
      end
      if (SPI_clk && !prev_sclk) begin
        if (rise_cnt < NBYTES * 8) rise_t[rise_cnt] = cyc;
        rise_cnt++;
        sh = {sh[6:0], MISO};
        bit_n++;
        if (bit_n == 8) begin
          bit_n = 0;
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL byte_extra: got %h, required no further byte", sh);
          end else begin
            want = exp_q.pop_front();
            if (sh !== want) begin
              n_fail++;
              $display("FAIL byte_%0d: got %h, required %h", rise_cnt / 8 - 1, sh, want);
            end
          end
        end
      end
      if (!SPI_clk && MISO === prev_miso) quiet++;
      else quiet = 0;
      if (quiet > max_quiet) max_quiet = quiet;
      prev_sclk = SPI_clk;
      prev_miso = MISO;
      prev_busy = busy;
    end
    if (reset_at == 0) begin
      n_tests++;
      if (!saw_done) begin
        n_fail++;
        $display("FAIL done_timeout: got no done within %0d cycles, required done", LIMIT);
      end
      n_tests++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL byte_missing: got %0d bytes short, required 0", exp_q.size());
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    chip_select = 1'b1;
    repeat (3) @(posedge CLK_40);
    @(negedge CLK_40);
    n_tests++;
    if ({SPI_clk, MISO, src_ready, busy, done} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, required 00000", {SPI_clk, MISO, src_ready, busy, done});
    end
    @(posedge CLK_40);
    #1 reset = 1'b0;
    begin
      int busy_seen = 0;
      repeat (20) begin
        @(negedge CLK_40);
        if (busy) busy_seen++;
      end
      n_tests++;
      if (busy_seen !== 0) begin
        n_fail++;
        $display("FAIL idle_no_start: got busy for %0d cycles, required 0", busy_seen);
      end
    end
  endtask

  task automatic test_basic();
    run_payload(-1, 0, 0, 1'b0);
    n_tests++;
    if (rise_cnt !== NBYTES * 8) begin
      n_fail++;
      $display("FAIL rise_count: got %0d, required %0d", rise_cnt, NBYTES * 8);
    end
    n_tests++;
    if (done_cnt !== 1) begin
      n_fail++;
      $display("FAIL done_count: got %0d, required 1", done_cnt);
    end
    n_tests++;
    if (ready_cnt !== PAY) begin
      n_fail++;
      $display("FAIL src_ready_count: got %0d, required %0d", ready_cnt, PAY);
    end
    n_tests++;
    if (busy_cyc !== 2) begin
      n_fail++;
      $display("FAIL start_latency: got busy at cycle %0d, required 2", busy_cyc);
    end
    n_tests++;
    if (rise_t[0] - busy_cyc !== H) begin
      n_fail++;
      $display("FAIL first_rise: got %0d, required %0d", rise_t[0] - busy_cyc, H);
    end
    n_tests++;
    if (rise_t[1] - rise_t[0] !== 2 * H) begin
      n_fail++;
      $display("FAIL bit_spacing: got %0d, required %0d", rise_t[1] - rise_t[0], 2 * H);
    end
`ifdef SPI_TX_GAP_EN
    n_tests++;
    if (rise_t[8*11] - rise_t[8*10+7] !== 4 * H + GAP) begin
      n_fail++;
      $display("FAIL gap_spacing: got %0d, required %0d", rise_t[8*11] - rise_t[8*10+7],
               4 * H + GAP);
    end
`else
    n_tests++;
    if (rise_t[8*11] - rise_t[8*10+7] !== 2 * H) begin
      n_fail++;
      $display("FAIL payload_spacing: got %0d, required %0d", rise_t[8*11] - rise_t[8*10+7],
               2 * H);
    end
    n_tests++;
    if (done_cyc - busy_cyc !== NBYTES * 16 * H) begin
      n_fail++;
      $display("FAIL payload_duration: got %0d, required %0d", done_cyc - busy_cyc,
               NBYTES * 16 * H);
    end
`endif
    @(negedge CLK_40);
    n_tests++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL after_done: got busy/done %b, required 00", {busy, done});
    end
  endtask

  task automatic test_stall();
    run_payload(5, 600, 0, 1'b0);
    n_tests++;
    if (max_quiet < 500) begin
      n_fail++;
      $display("FAIL stall_quiet: got %0d quiet cycles, required >= 500", max_quiet);
    end
    n_tests++;
    if (rise_cnt !== NBYTES * 8 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL stall_counts: got %0d rises %0d done, required %0d and 1", rise_cnt,
               done_cnt, NBYTES * 8);
    end
  endtask

  task automatic test_reset_abort();
    int busy_seen = 0;
    int done_seen = 0;
    run_payload(-1, 0, 5000, 1'b0);
    @(posedge CLK_40);
    #1 reset = 1'b0;
    repeat (300) begin
      @(negedge CLK_40);
      if (busy) busy_seen++;
      if (done) done_seen++;
    end
    n_tests++;
    if (busy_seen !== 0 || done_seen !== 0) begin
      n_fail++;
      $display("FAIL abort_quiet: got busy %0d done %0d cycles, required 0 and 0", busy_seen,
               done_seen);
    end
    run_payload(-1, 0, 0, 1'b0);
    n_tests++;
    if (done_cnt !== 1) begin
      n_fail++;
      $display("FAIL restart_done: got %0d, required 1", done_cnt);
    end
  endtask

  task automatic test_cs_toggle();
    run_payload(-1, 0, 0, 1'b1);
    n_tests++;
    if (rise_cnt !== NBYTES * 8 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL toggle_counts: got %0d rises %0d done, required %0d and 1", rise_cnt,
               done_cnt, NBYTES * 8);
    end
`ifndef SPI_TX_GAP_EN
    n_tests++;
    if (done_cyc - busy_cyc !== NBYTES * 16 * H) begin
      n_fail++;
      $display("FAIL toggle_duration: got %0d, required %0d", done_cyc - busy_cyc,
               NBYTES * 16 * H);
    end
`endif
  endtask

  initial begin
    pat[0] = 8'hBB;
    pat[1] = 8'hA0;
    pat[2] = 8'hD2;
    test_reset();
    test_basic();
    test_stall();
    test_reset_abort();
    test_cs_toggle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got no completion, required bench to finish");
    $fatal(1, "watchdog expired");
  end

endmodule
